// File: rtl/sram_1rw1r_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_1rw1r_sync_if
// Description : Request/response bundle for the 1RW1R synchronous memory.
//               master drives requests (port 0 read/write, port 1 read);
//               slave is the memory, returning registered read data, ready
//               and the collision pulse.
// Signals     : csb0/web0/wmask0/addr0/din0 -> port 0 request
//               dout0                       <- port 0 read data
//               csb1/addr1                  -> port 1 request
//               dout1                       <- port 1 read data
//               ready, collision            <- status
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_1rw1r_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_WMASKS = 4
);
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  ready;
    logic                  collision;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, dout1, ready, collision
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, dout1, ready, collision
    );
endinterface
`default_nettype wire

// File: rtl/sram_1rw1r_sync.sv
`default_nettype none
// ============================================================================
// Module      : sram_1rw1r_sync
// Description : Parametrised single-clock memory with one read/write port
//               (port 0, byte-lane masked writes) and one read-only port
//               (port 1). Optional zero-fill sequence after reset, registered
//               outputs that hold when idle, and same-address write/read
//               collision detection with selectable new/old data on port 1.
// Ports       : clk0 - clock, all activity on posedge
//               rst0 - synchronous reset, active-high
//               bus  - sram_1rw1r_sync_if.slave (requests, read data, status)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw1r_sync #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 9,
    parameter int NUM_WMASKS    = 4,
    parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
    parameter int INIT_ON_RESET = 1,
    parameter int BYPASS        = 1
) (
    input  wire logic         clk0,
    input  wire logic         rst0,
    sram_1rw1r_sync_if.slave  bus
);

    localparam int                    c_LANE_W = DATA_WIDTH / NUM_WMASKS;
    localparam logic [ADDR_WIDTH-1:0] c_LAST   = ADDR_WIDTH'(RAM_DEPTH - 1);

    generate
        if ((DATA_WIDTH % NUM_WMASKS) != 0) begin : g_bad_lane_width
            $error("sram_1rw1r_sync: DATA_WIDTH must be a multiple of NUM_WMASKS");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_dout0;
    logic [DATA_WIDTH-1:0] r_dout1;
    logic                  r_ready;
    logic                  r_collision;

    logic                  w_run;
    logic                  w_wr_en;
    logic                  w_rd0;
    logic                  w_rd1;
    logic                  w_collision;
    logic [DATA_WIDTH-1:0] w_old0;
    logic [DATA_WIDTH-1:0] w_merged;

    // Requests are only honoured in RUN; during INIT both chip selects are
    // treated as deasserted. A zero-mask write touches nothing, so it is
    // not a write for collision purposes either.
    always_comb begin
        w_run       = (r_state == ST_RUN);
        w_wr_en     = w_run && !bus.csb0 && !bus.web0 && (|bus.wmask0);
        w_rd0       = w_run && !bus.csb0 && bus.web0;
        w_rd1       = w_run && !bus.csb1;
        w_collision = w_wr_en && w_rd1 && (bus.addr0 == bus.addr1);
        w_old0      = r_mem[bus.addr0];
        w_merged    = w_old0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (bus.wmask0[i]) begin
                w_merged[i*c_LANE_W +: c_LANE_W] = bus.din0[i*c_LANE_W +: c_LANE_W];
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            // Memory contents are deliberately not touched here: with
            // INIT_ON_RESET = 0 they survive reset, otherwise INIT clears them.
            r_dout0     <= '0;
            r_dout1     <= '0;
            r_collision <= 1'b0;
            r_init_cnt  <= '0;
            r_state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            r_ready     <= (INIT_ON_RESET == 0);
        end else begin
            r_collision <= w_collision;
            case (r_state)
                ST_INIT: begin
                    r_mem[r_init_cnt] <= '0;
                    r_init_cnt        <= r_init_cnt + ADDR_WIDTH'(1);
                    if (r_init_cnt == c_LAST) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_wr_en) begin
                        r_mem[bus.addr0] <= w_merged;
                    end
                    if (w_rd0) begin
                        r_dout0 <= w_old0;
                    end
                    if (w_rd1) begin
                        // On a same-address collision the merged word is the
                        // value being committed at this very edge.
                        r_dout1 <= (w_collision && (BYPASS != 0)) ? w_merged
                                                                   : r_mem[bus.addr1];
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.dout0     = r_dout0;
    assign bus.dout1     = r_dout1;
    assign bus.ready     = r_ready;
    assign bus.collision = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw1r_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_1rw1r_sync
// Description : Self-checking bench for sram_1rw1r_sync (16 x 32, 4 lanes).
//               Two instances share one stimulus stream: u_dut_a with new-data
//               bypass, u_dut_b with old-data on collision.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_1rw1r_sync;

    logic clk0 = 1'b0;
    logic rst0;

    always #5 clk0 = ~clk0;

    sram_1rw1r_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_WMASKS(4)) bus_a ();
    sram_1rw1r_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_WMASKS(4)) bus_b ();

    assign bus_b.csb0   = bus_a.csb0;
    assign bus_b.web0   = bus_a.web0;
    assign bus_b.wmask0 = bus_a.wmask0;
    assign bus_b.addr0  = bus_a.addr0;
    assign bus_b.din0   = bus_a.din0;
    assign bus_b.csb1   = bus_a.csb1;
    assign bus_b.addr1  = bus_a.addr1;

    sram_1rw1r_sync #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_WMASKS(4), .RAM_DEPTH(16),
        .INIT_ON_RESET(1), .BYPASS(1)
    ) u_dut_a (
        .clk0 (clk0),
        .rst0 (rst0),
        .bus  (bus_a.slave)
    );

    sram_1rw1r_sync #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_WMASKS(4), .RAM_DEPTH(16),
        .INIT_ON_RESET(1), .BYPASS(0)
    ) u_dut_b (
        .clk0 (clk0),
        .rst0 (rst0),
        .bus  (bus_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        csb0;
        logic        web0;
        logic [3:0]  wmask0;
        logic [3:0]  addr0;
        logic [31:0] din0;
        logic        csb1;
        logic [3:0]  addr1;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic [31:0] e_d1b;
        logic        e_col;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(logic c0, logic w0, logic [3:0] m, logic [3:0] a0,
                                logic [31:0] d, logic c1, logic [3:0] a1,
                                logic [31:0] ed0, logic [31:0] ed1,
                                logic [31:0] ed1b, logic ecol);
        vec_t v;
        v.csb0 = c0;  v.web0 = w0; v.wmask0 = m; v.addr0 = a0; v.din0 = d;
        v.csb1 = c1;  v.addr1 = a1;
        v.e_d0 = ed0; v.e_d1 = ed1; v.e_d1b = ed1b; v.e_col = ecol;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c0, input logic w0, input logic [3:0] m,
                         input logic [3:0] a0, input logic [31:0] d,
                         input logic c1, input logic [3:0] a1);
        bus_a.csb0 = c0; bus_a.web0 = w0; bus_a.wmask0 = m;
        bus_a.addr0 = a0; bus_a.din0 = d;
        bus_a.csb1 = c1; bus_a.addr1 = a1;
    endtask

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    // Scoreboard state for the random phase
    logic [31:0] mm [16];
    logic [31:0] e_d0, e_d1, e_d1b, merged;
    logic        e_col, wr;

    initial begin
        rst0 = 1'b1;
        drive(1, 1, 4'h0, 4'h0, 32'h0, 1, 4'h0);
        step();
        step();
        chk("reset_dout0", bus_a.dout0, 32'h0);
        chk("reset_dout1", bus_a.dout1, 32'h0);
        chk("reset_collision", {31'b0, bus_a.collision}, 32'h0);
        chk("reset_ready", {31'b0, bus_a.ready}, 32'h0);

        // Partial init with requests active, then reset lands on the 7th edge
        rst0 = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            drive(0, 0, 4'hF, 4'(e), 32'hFFFF_FFFF, 0, 4'(e));
            step();
            chk("partial_init_ready", {31'b0, bus_a.ready}, 32'h0);
        end
        rst0 = 1'b1;
        step();
        chk("midinit_reset_ready", {31'b0, bus_a.ready}, 32'h0);
        chk("midinit_reset_dout1", bus_a.dout1, 32'h0);
        rst0 = 1'b0;

        // Full init: ready must rise exactly after the 16th edge; requests
        // issued meanwhile must be ignored.
        for (int e = 1; e <= 16; e++) begin
            drive(0, 0, 4'hF, 4'(e - 1), 32'hA5A5_0000 | 32'(e), 0, 4'(e - 1));
            step();
            chk("init_ready", {31'b0, bus_a.ready}, {31'b0, (e == 16)});
            chk("init_ready_b", {31'b0, bus_b.ready}, {31'b0, (e == 16)});
            chk("init_collision", {31'b0, bus_a.collision}, 32'h0);
            chk("init_dout1", bus_a.dout1, 32'h0);
        end

        // Every word reads back zero on both ports
        for (int a = 0; a < 16; a++) begin
            drive(0, 1, 4'h0, 4'(a), 32'h0, 0, 4'(15 - a));
            step();
            chk("zero_dout0", bus_a.dout0, 32'h0);
            chk("zero_dout1", bus_a.dout1, 32'h0);
        end

        // Directed vector table
        vecs[0]  = mk(0, 0, 4'hF, 4'd3, 32'hAABBCCDD, 1, 4'd0, 32'h0, 32'h0, 32'h0, 0);
        vecs[1]  = mk(0, 0, 4'h5, 4'd3, 32'h11223344, 1, 4'd0, 32'h0, 32'h0, 32'h0, 0);
        vecs[2]  = mk(0, 1, 4'h0, 4'd3, 32'h0, 1, 4'd0, 32'hAA22CC44, 32'h0, 32'h0, 0);
        vecs[3]  = mk(1, 1, 4'h0, 4'd0, 32'h0, 0, 4'd3, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 0);
        for (int i = 4; i <= 8; i++)
            vecs[i] = mk(0, 0, 4'hF, 4'd3, 32'h55555555, 1, 4'd3,
                         32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 0);
        vecs[9]  = mk(0, 1, 4'h0, 4'd3, 32'h0, 0, 4'd3, 32'h55555555, 32'h55555555, 32'h55555555, 0);
        vecs[10] = mk(0, 0, 4'h3, 4'd5, 32'hDEADBEEF, 0, 4'd5, 32'h55555555, 32'h0000BEEF, 32'h0, 1);
        vecs[11] = mk(1, 1, 4'h0, 4'd0, 32'h0, 1, 4'd0, 32'h55555555, 32'h0000BEEF, 32'h0, 0);
        vecs[12] = mk(0, 1, 4'h0, 4'd5, 32'h0, 0, 4'd5, 32'h0000BEEF, 32'h0000BEEF, 32'h0000BEEF, 0);
        vecs[13] = mk(0, 0, 4'h0, 4'd5, 32'hFFFFFFFF, 0, 4'd5, 32'h0000BEEF, 32'h0000BEEF, 32'h0000BEEF, 0);
        vecs[14] = mk(0, 1, 4'h0, 4'd5, 32'h0, 1, 4'd0, 32'h0000BEEF, 32'h0000BEEF, 32'h0000BEEF, 0);
        vecs[15] = mk(0, 0, 4'hF, 4'd6, 32'hFFFFFFFF, 0, 4'd5, 32'h0000BEEF, 32'h0000BEEF, 32'h0000BEEF, 0);
        vecs[16] = mk(0, 0, 4'h8, 4'd7, 32'h12345678, 0, 4'd7, 32'h0000BEEF, 32'h12000000, 32'h0, 1);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].csb0, vecs[i].web0, vecs[i].wmask0, vecs[i].addr0,
                  vecs[i].din0, vecs[i].csb1, vecs[i].addr1);
            step();
            chk($sformatf("vec%0d_dout0", i), bus_a.dout0, vecs[i].e_d0);
            chk($sformatf("vec%0d_dout1", i), bus_a.dout1, vecs[i].e_d1);
            chk($sformatf("vec%0d_dout1_old", i), bus_b.dout1, vecs[i].e_d1b);
            chk($sformatf("vec%0d_collision", i), {31'b0, bus_a.collision}, {31'b0, vecs[i].e_col});
            chk($sformatf("vec%0d_collision_b", i), {31'b0, bus_b.collision}, {31'b0, vecs[i].e_col});
        end

        // Collision is a single-cycle pulse
        drive(1, 1, 4'h0, 4'd0, 32'h0, 1, 4'd0);
        step();
        chk("collision_pulse_end", {31'b0, bus_a.collision}, 32'h0);

        // Random full-rate traffic against a scoreboard
        for (int a = 0; a < 16; a++) mm[a] = 32'h0;
        mm[3] = 32'h55555555; mm[5] = 32'h0000BEEF;
        mm[6] = 32'hFFFFFFFF; mm[7] = 32'h12000000;
        e_d0 = 32'h0000BEEF; e_d1 = 32'h12000000; e_d1b = 32'h0;
        for (int c = 0; c < 2000; c++) begin
            logic        c0, w0, c1;
            logic [3:0]  m, a0, a1;
            logic [31:0] d;
            c0 = ($urandom_range(0, 3) == 0);
            w0 = 1'($urandom_range(0, 1));
            c1 = ($urandom_range(0, 3) == 0);
            m  = 4'($urandom_range(0, 15));
            a0 = 4'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 2) == 0) ? a0 : 4'($urandom_range(0, 15));
            d  = $urandom;
            drive(c0, w0, m, a0, d, c1, a1);

            wr     = !c0 && !w0 && (m != 4'h0);
            e_col  = wr && !c1 && (a0 == a1);
            merged = mm[a0];
            for (int l = 0; l < 4; l++)
                if (m[l]) merged[l*8 +: 8] = d[l*8 +: 8];
            if (!c0 && w0) e_d0 = mm[a0];
            if (!c1) begin
                e_d1  = e_col ? merged : mm[a1];
                e_d1b = mm[a1];
            end
            if (wr) mm[a0] = merged;

            step();
            chk("rand_dout0", bus_a.dout0, e_d0);
            chk("rand_dout1", bus_a.dout1, e_d1);
            chk("rand_dout1_old", bus_b.dout1, e_d1b);
            chk("rand_collision", {31'b0, bus_a.collision}, {31'b0, e_col});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_1rw1r_sync.md
Name: sram_1rw1r_sync

Overview:
- Parametrised synchronous memory with one read/write port (port 0) and one read-only port (port 1). It is the next generation of the OpenRAM-style 1RW1R behavioural model.
- Adds the following over the previous model:
  - configurable width, depth and byte-lane count;
  - a single clock with synchronous reset;
  - optional zero-initialisation state machine after reset;
  - deterministic output hold (never X);
  - write-to-read collision detection, with a selectable bypass on port 1.
- Sits behind the SoC bus-to-SRAM adapters as the drop-in memory for simulation and FPGA builds.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be an integer multiple of NUM_WMASKS (elaboration error otherwise).
- ADDR_WIDTH, 9, address bits.
- NUM_WMASKS, 4, number of write-enable lanes; lane width = DATA_WIDTH/NUM_WMASKS.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words.
- INIT_ON_RESET, 1, 1 = clear every word after reset; 0 = contents untouched by reset.
- BYPASS, 1, port-1 behaviour on same-address write collision: 1 = new data, 0 = old data.

Ports:
- clk0  input  1  single clock for both ports; all activity on posedge.
- rst0  input  1  synchronous reset, active-high.
- csb0  input  1  port 0 chip select, active-low.
- web0  input  1  port 0 write enable, active-low.
- wmask0  input  NUM_WMASKS  per-lane write enable, 1 = write lane.
- addr0  input  ADDR_WIDTH  port 0 address.
- din0  input  DATA_WIDTH  port 0 write data.
- dout0  output  DATA_WIDTH  port 0 read data, registered.
- csb1  input  1  port 1 chip select, active-low.
- addr1  input  ADDR_WIDTH  port 1 address.
- dout1  output  DATA_WIDTH  port 1 read data, registered.
- ready  output  1  1 = accepting requests.
- collision  output  1  one-cycle pulse on same-address write/read.

Behaviour:
- Reset (rst0 high at posedge):
  - dout0 = 0, dout1 = 0, collision = 0, init counter = 0.
  - State = INIT if INIT_ON_RESET = 1, otherwise RUN.
  - ready = 0 if INIT_ON_RESET = 1, otherwise 1.
  - Reset asserted mid-INIT or mid-RUN aborts all activity and restarts from this point; no partial write is committed on a reset edge.
- INIT state:
  - Each posedge writes 0 to mem[counter] and increments the counter.
  - The edge that writes word RAM_DEPTH-1 moves to RUN and sets ready = 1. ready is therefore first high after exactly RAM_DEPTH posedges with rst0 low.
  - csb0/csb1 are ignored (treated as 1); dout0/dout1 hold 0; collision stays 0.
- RUN state, port 0:
  - Write, when posedge sees csb0 = 0 and web0 = 0: for each lane i with wmask0[i] = 1, mem[addr0] lane i <= din0 lane i. Other lanes are unchanged. dout0 holds its previous value.
  - Read, when csb0 = 0 and web0 = 1: dout0 <= mem[addr0] at the same edge, so data is valid one cycle after the request.
  - When csb0 = 1: no memory access; dout0 holds.
- RUN state, port 1:
  - When csb1 = 0: dout1 <= mem[addr1] at the same edge (one-cycle latency).
  - When csb1 = 1: dout1 holds.
- Collision: same edge with a port-0 write (csb0 = 0, web0 = 0, wmask0 != 0), a port-1 read (csb1 = 0) and addr0 == addr1.
  - collision = 1 for exactly one cycle; otherwise collision = 0 at every edge.
  - BYPASS = 1: dout1 = merged word (masked lanes from din0, unmasked lanes from old contents).
  - BYPASS = 0: dout1 = old contents.
- A write with wmask0 = 0 is a no-op: no memory change, no collision.
- A port-0 read and a port-1 read of the same address in the same cycle both return the same stored word.
- Back-to-back accesses are allowed every cycle on both ports; there are no stall states.
- An address is always in range (RAM_DEPTH = 2^ADDR_WIDTH); there is no wrap handling beyond natural truncation.

Test Plan:
- Reset/init with ADDR_WIDTH = 4, INIT_ON_RESET = 1: release rst0 -> ready = 0 for 16 edges, ready = 1 after the 16th edge. Reading every address on both ports -> 0x00000000.
- Masked write: write addr 3, din0 = 0xAABBCCDD, wmask0 = 4'b1111; then write addr 3, din0 = 0x11223344, wmask0 = 4'b0101; then read addr 3 on port 0 -> dout0 = 0xAA22CC44 one cycle after the request.
- Collision with BYPASS = 1: mem[5] = 0x0; same cycle port-0 write addr 5, 0xDEADBEEF, mask 4'b0011, and port-1 read addr 5 -> dout1 = 0x0000BEEF, collision = 1 for one cycle. With BYPASS = 0 -> dout1 = 0x00000000, collision = 1.
- Hold: read addr 3 (0xAA22CC44) on port 1, then csb1 = 1 for 5 cycles while port 0 writes addr 3 -> dout1 stays 0xAA22CC44. A port-0 write never changes dout0.
- Reset mid-init: assert rst0 at the 7th init edge -> ready stays 0, counter restarts, ready rises 16 edges after release. Requests issued during INIT -> no writes land (verify by reads after ready).
- Full-rate traffic: random port-0 reads/writes and port-1 reads every cycle for 2000 cycles vs scoreboard model -> zero mismatches; collision asserted exactly on the model-predicted cycles.
